rng_share_ctrl: RTL and testbench
=================================

# rng_share_ctrl

Controller that owns the single 16-bit LFSR entropy source (shift-right, feedback into bit 15 = parity(poly & state), free-running when not loading) and shares it between NUM_REQ requesters. It seeds the LFSR, waits out a warm-up period, and hands each requester a fresh 16-bit word under round-robin arbitration. It also detects and recovers from the all-zero lock-up state. It sits between the CSR/config path, the requesting units and the LFSR instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WARMUP, 32, LFSR shift cycles after a load before the first grant (min 16)
- DEFAULT_SEED, 16'hACE1, seed used after reset, on zero-seed writes and on lock-up recovery
- DEFAULT_POLY, 16'hB400, tap mask used after reset
- RESEED_PERIOD, 256, grants between automatic reseeds (RNG_RESEED_EN only)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_we_i  in  1  one-cycle pulse: latch cfg_seed_i/cfg_poly_i and reseed
- cfg_seed_i  in  16  new seed
- cfg_poly_i  in  16  new tap mask
- req_i  in  NUM_REQ  level request; held by requester until its grant
- gnt_o  out  NUM_REQ  one-hot, one-cycle grant; data_o valid in the same cycle
- data_o  out  16  random word for the granted requester
- ready_o  out  1  high in READY state
- stuck_err_o  out  1  sticky: all-zero LFSR state detected
- lfsr_load_o  out  1  load strobe to LFSR
- lfsr_seed_o  out  16  seed to LFSR (holds the seed register)
- lfsr_poly_o  out  16  tap mask to LFSR (holds the poly register)
- lfsr_data_i  in  16  LFSR state
- lfsr_valid_i  in  1  LFSR has shifted since the last load

## Operation
- States: LOAD, WARMUP, READY.
- Reset values: state LOAD; seed register DEFAULT_SEED; poly register DEFAULT_POLY; gnt_o 0, data_o 0, ready_o 0, stuck_err_o 0; RR pointer 0; fresh counter 0; warm-up counter 0.
- LOAD (exactly 1 cycle):
  - lfsr_load_o = 1, decoded combinationally from the state.
  - Clear the warm-up and fresh counters, then go to WARMUP.
- WARMUP:
  - Count cycles with lfsr_valid_i = 1.
  - When the count reaches WARMUP, go to READY with the fresh counter at 16.
- READY:
  - The fresh counter increments on every shift and saturates at 16.
  - A grant is issued only when fresh = 16 and req_i is non-zero.
  - Round-robin search starts at the index after the last winner; after reset it starts at index 0.
  - At the grant edge: gnt_o is set one-hot, data_o <= lfsr_data_i, the fresh counter is reset to 0 and the pointer moves to winner+1 mod NUM_REQ.
  - Consecutive grants are therefore at least 17 cycles apart, so no word bit is ever reused.
- Lock-up: lfsr_data_i == 0 in READY sets stuck_err_o, sets seed to DEFAULT_SEED and goes to LOAD. No grant is issued that cycle.
- cfg_we_i, in any state:
  - Latch poly from cfg_poly_i.
  - Latch seed from cfg_seed_i, or DEFAULT_SEED if cfg_seed_i is 0.
  - Go to LOAD. Any grant pending that cycle is suppressed.
  - cfg_we_i has priority over lock-up detection and over grants.
- stuck_err_o clears only on reset.

## Timing
- The first LOAD is in the first cycle after reset release. WARMUP+1 shift cycles later ready_o = 1.
- Request to grant is 1 cycle minimum: req is sampled at edge N, and gnt_o/data_o are valid during cycle N+1.
- gnt_o is high for exactly one cycle. The requester drops req_i in the grant cycle or the cycle after; a still-high req in the grant cycle is ignored because fresh < 16.
- Deasserting req_i before its grant is permitted and no grant is issued for it.

## Configuration
- RNG_RESEED_EN defined:
  - A grant counter counts grants. At RESEED_PERIOD it sets seed <= lfsr_data_i ^ {grant_count[7:0], 8'h5A}, enters LOAD after that grant, and clears itself.
  - A zero result is replaced by DEFAULT_SEED.
- RNG_RESEED_EN undefined: no grant counter; reseed happens only on reset, cfg_we_i or lock-up.

## Structure
- Package rng_pkg holds:
  - the state enum,
  - RNG_W = 16,
  - the FRESH_SHIFTS = 16 constant,
  - the default seed and poly constants.
- Sub-module rr_arb (NUM_REQ-wide round-robin arbiter with pointer input, one-hot output). All other logic stays in rng_share_ctrl.

## Test plan
- Reset release with defaults: lfsr_load_o high for cycle 1 with lfsr_seed_o = 16'hACE1; ready_o rises after 33 shift cycles.
- req_i = 4'b1111 held: grants go 0,1,2,3,0 with spacing of exactly 17 cycles; data_o equals the model LFSR state at each grant edge.
- cfg_we_i with seed 16'h0000, poly 16'h1234 mid-grant: no gnt_o that cycle; load uses 16'hACE1; ready_o drops for the warm-up.
- Poly 16'h0000 written: state reaches 0 within 16 shifts; stuck_err_o sets; reload with 16'hACE1; stuck_err_o stays 1.
- req_i[2] pulsed for 1 cycle while fresh < 16: no grant to requester 2.
- RNG_RESEED_EN with RESEED_PERIOD = 4: after the 4th grant, lfsr_load_o pulses with seed = data ^ 16'h045A.

Source files
------------

// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types and constants for rng_share_ctrl
package rng_pkg;

  localparam int RNG_W        = 16;
  localparam int FRESH_SHIFTS = 16;
  localparam int FRESH_W      = 5;

  localparam logic [RNG_W-1:0] RNG_DEFAULT_SEED = 16'hACE1;
  localparam logic [RNG_W-1:0] RNG_DEFAULT_POLY = 16'hB400;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_WARMUP,
    ST_READY
  } rng_state_e;

  // An all-zero seed would lock the LFSR, so it is swapped for the fallback.
  function automatic logic [RNG_W-1:0] nz_seed(input logic [RNG_W-1:0] s,
                                               input logic [RNG_W-1:0] dflt);
    return (s == '0) ? dflt : s;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin arbiter, search starts at ptr and wraps
module rr_arb #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          found
);

  // First pass covers ptr..N-1, second pass wraps to the low indices.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = PW'(i);
      end
    end
  end

endmodule

// File: rtl/rng_share_ctrl.sv
// rtl/rng_share_ctrl.sv - seeds, warms up and shares one LFSR among requesters
// Optional periodic reseed after RESEED_PERIOD grants: define RNG_RESEED_EN.
module rng_share_ctrl
  import rng_pkg::*;
#(
  parameter int          NUM_REQ      = 4,
  parameter int          WARMUP       = 32,
  parameter logic [15:0] DEFAULT_SEED = RNG_DEFAULT_SEED,
  parameter logic [15:0] DEFAULT_POLY = RNG_DEFAULT_POLY
`ifdef RNG_RESEED_EN
  ,
  parameter int          RESEED_PERIOD = 256
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we_i,
  input  logic [15:0]        cfg_seed_i,
  input  logic [15:0]        cfg_poly_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [15:0]        data_o,
  output logic               ready_o,
  output logic               stuck_err_o,
  output logic               lfsr_load_o,
  output logic [15:0]        lfsr_seed_o,
  output logic [15:0]        lfsr_poly_o,
  input  logic [15:0]        lfsr_data_i,
  input  logic               lfsr_valid_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(WARMUP + 1);

  rng_state_e         state_q, state_d;
  logic [WW-1:0]      warm_q;
  logic [FRESH_W-1:0] fresh_q;
  logic [PW-1:0]      ptr_q, ptr_nxt;
  logic [RNG_W-1:0]   seed_q, poly_q;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               arb_found;
  logic               lock_det, do_grant;
`ifdef RNG_RESEED_EN
  logic               do_reseed;
  logic [15:0]        gcnt_q, gcnt_inc;
  assign gcnt_inc = gcnt_q + 16'd1;
`endif

  assign lfsr_seed_o = seed_q;
  assign lfsr_poly_o = poly_q;
  assign ptr_nxt     = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  rr_arb #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    lock_det = 1'b0;
    do_grant = 1'b0;
`ifdef RNG_RESEED_EN
    do_reseed = 1'b0;
`endif
    lfsr_load_o = (state_q == ST_LOAD);
    ready_o     = (state_q == ST_READY);
    case (state_q)
      ST_LOAD:   state_d = ST_WARMUP;
      ST_WARMUP: if (lfsr_valid_i && (warm_q == WW'(WARMUP - 1))) state_d = ST_READY;
      ST_READY: begin
        if (lfsr_data_i == '0) begin
          lock_det = 1'b1;
          state_d  = ST_LOAD;
        end else if ((fresh_q == FRESH_W'(FRESH_SHIFTS)) && arb_found) begin
          do_grant = 1'b1;
`ifdef RNG_RESEED_EN
          if (gcnt_inc == 16'(RESEED_PERIOD)) begin
            do_reseed = 1'b1;
            state_d   = ST_LOAD;
          end
`endif
        end
      end
      default: state_d = ST_LOAD;
    endcase
    // A config write wins over lock-up recovery and over any pending grant.
    if (cfg_we_i) begin
      state_d  = ST_LOAD;
      lock_det = 1'b0;
      do_grant = 1'b0;
`ifdef RNG_RESEED_EN
      do_reseed = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q      <= DEFAULT_SEED;
      poly_q      <= DEFAULT_POLY;
      gnt_o       <= '0;
      data_o      <= '0;
      stuck_err_o <= 1'b0;
      ptr_q       <= '0;
      fresh_q     <= '0;
      warm_q      <= '0;
    end else begin
      gnt_o <= '0;
      case (state_q)
        ST_LOAD: begin
          warm_q  <= '0;
          fresh_q <= '0;
        end
        ST_WARMUP: begin
          if (lfsr_valid_i) warm_q <= warm_q + 1'b1;
          if (state_d == ST_READY) fresh_q <= FRESH_W'(FRESH_SHIFTS);
        end
        ST_READY: begin
          if (lfsr_valid_i && (fresh_q != FRESH_W'(FRESH_SHIFTS))) fresh_q <= fresh_q + 1'b1;
        end
        default: ;
      endcase
      if (do_grant) begin
        gnt_o   <= arb_gnt;
        data_o  <= lfsr_data_i;
        fresh_q <= '0;
        ptr_q   <= ptr_nxt;
      end
      if (lock_det) begin
        stuck_err_o <= 1'b1;
        seed_q      <= DEFAULT_SEED;
      end
`ifdef RNG_RESEED_EN
      if (do_reseed) seed_q <= nz_seed(lfsr_data_i ^ {gcnt_inc[7:0], 8'h5A}, DEFAULT_SEED);
`endif
      if (cfg_we_i) begin
        poly_q <= cfg_poly_i;
        seed_q <= nz_seed(cfg_seed_i, DEFAULT_SEED);
      end
    end
  end

`ifdef RNG_RESEED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         gcnt_q <= '0;
    else if (do_reseed) gcnt_q <= '0;
    else if (do_grant)  gcnt_q <= gcnt_inc;
  end
`endif

endmodule

// File: tb/tb_rng_share_ctrl.sv
// tb/tb_rng_share_ctrl.sv - randomized bench with LFSR stand-in and reference model
module tb_rng_share_ctrl;

  localparam int          N        = 4;
  localparam int          WU       = 32;
  localparam int          RP       = 4;
  localparam logic [15:0] DEF_SEED = 16'hACE1;
  localparam logic [15:0] DEF_POLY = 16'hB400;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [15:0]   cfg_seed = '0;
  logic [15:0]   cfg_poly = '0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt_o;
  logic [15:0]   data_o;
  logic          ready_o, stuck_err_o, lfsr_load_o;
  logic [15:0]   lfsr_seed_o, lfsr_poly_o;
  logic [15:0]   lfsr = '0;
  logic          lvalid = 1'b0;

  int checks = 0;
  int failures = 0;

  // LFSR stand-in bookkeeping
  int shifts = 0;

  // reference model state
  bit           pend_load;
  logic [15:0]  m_seed, m_poly, m_data;
  bit           m_stuck;
  logic [N-1:0] exp_gnt;
  int           quiet, m_ptr, gcount;
  bit [N-1:0]   pulse;

  always #5 clk = ~clk;

  rng_share_ctrl #(
    .NUM_REQ(N),
    .WARMUP (WU)
`ifdef RNG_RESEED_EN
    ,
    .RESEED_PERIOD(RP)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_seed_i  (cfg_seed),
    .cfg_poly_i  (cfg_poly),
    .req_i       (req),
    .gnt_o       (gnt_o),
    .data_o      (data_o),
    .ready_o     (ready_o),
    .stuck_err_o (stuck_err_o),
    .lfsr_load_o (lfsr_load_o),
    .lfsr_seed_o (lfsr_seed_o),
    .lfsr_poly_o (lfsr_poly_o),
    .lfsr_data_i (lfsr),
    .lfsr_valid_i(lvalid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int cyc);
    logic         load_s;
    logic [15:0]  seed_s, poly_s;
    logic [N-1:0] gnt_s;
    bit           exp_ready;
    int           w;
    @(negedge clk);
    exp_ready = !pend_load && (shifts >= WU + 1);
    check("lfsr_load", lfsr_load_o, pend_load);
    if (pend_load) check("lfsr_seed", lfsr_seed_o, m_seed);
    check("lfsr_poly", lfsr_poly_o, m_poly);
    check("ready", ready_o, exp_ready);
    check("stuck_err", stuck_err_o, m_stuck);
    check("gnt", gnt_o, exp_gnt);
    check("data", data_o, m_data);
    load_s = lfsr_load_o;
    seed_s = lfsr_seed_o;
    poly_s = lfsr_poly_o;
    gnt_s  = gnt_o;

    // predict what the next cycle must show
    if (pend_load) quiet = 1000;
    exp_gnt   = '0;
    pend_load = 0;
    if (cfg_we) begin
      m_poly    = cfg_poly;
      m_seed    = (cfg_seed == 16'h0) ? DEF_SEED : cfg_seed;
      pend_load = 1;
    end else if (exp_ready && lfsr == 16'h0) begin
      m_stuck   = 1;
      m_seed    = DEF_SEED;
      pend_load = 1;
    end else if (exp_ready && quiet >= 17 && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      exp_gnt = N'(1 << w);
      m_data  = lfsr;
      m_ptr   = (w + 1) % N;
      quiet   = 0;
`ifdef RNG_RESEED_EN
      gcount++;
      if (gcount == RP) begin
        m_seed = lfsr ^ {8'(RP), 8'h5A};
        if (m_seed == 16'h0) m_seed = DEF_SEED;
        gcount    = 0;
        pend_load = 1;
      end
`endif
    end
    quiet++;

    @(posedge clk);
    #1;
    if (load_s) begin
      lfsr   = seed_s;
      shifts = 0;
      lvalid = 1'b0;
    end else begin
      lfsr   = {^(poly_s & lfsr), lfsr[15:1]};
      shifts++;
      lvalid = 1'b1;
    end

    cfg_we = 1'b0;
    if (cyc == 300) begin
      cfg_we = 1'b1; cfg_seed = 16'h0000; cfg_poly = 16'h1234;
    end else if (cyc == 700) begin
      cfg_we = 1'b1; cfg_seed = 16'($urandom) | 16'h1; cfg_poly = 16'h0000;
    end else if (cyc == 800 || (cyc > 1000 && $urandom_range(0, 399) == 0)) begin
      cfg_we   = 1'b1;
      cfg_seed = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cfg_poly = DEF_POLY;
    end

    for (int i = 0; i < N; i++) begin
      if (cyc < 120) begin
        req[i] = 1'b1;
      end else if (req[i] && (gnt_s[i] || pulse[i] || $urandom_range(0, 199) == 0)) begin
        req[i]   = 1'b0;
        pulse[i] = 1'b0;
      end else if (!req[i] && $urandom_range(0, 7) == 0) begin
        req[i]   = 1'b1;
        pulse[i] = ($urandom_range(0, 4) == 0);
      end
    end
  endtask

  initial begin
    pend_load = 1;
    m_seed    = DEF_SEED;
    m_poly    = DEF_POLY;
    m_data    = '0;
    m_stuck   = 0;
    exp_gnt   = '0;
    quiet     = 1000;
    m_ptr     = 0;
    gcount    = 0;
    pulse     = '0;

    repeat (3) @(negedge clk);
    check("rst_gnt", gnt_o, '0);
    check("rst_data", data_o, '0);
    check("rst_ready", ready_o, 1'b0);
    check("rst_stuck", stuck_err_o, 1'b0);
    check("rst_seed", lfsr_seed_o, DEF_SEED);
    check("rst_poly", lfsr_poly_o, DEF_POLY);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int cyc = 1; cyc <= 2500 && failures < 40; cyc++) step(cyc);

    check("stuck_sticky_end", stuck_err_o, m_stuck);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
